fp16_round_pipe: RTL and testbench

Two-stage pipelined rounding unit for half precision. It consumes the normalizer's output: a normalized significand with one whole bit, plus guard, round and sticky bits, the underflow flag and the upstream inexact flag. It produces a packed IEEE 754 binary16 result with exception flags. It sits directly downstream of the normalization stage in the FP16 datapath and adds valid/ready flow control with back-pressure.

---
 rtl/fp16Pkg.sv | 41 ++++
 rtl/fp16_round_inc.sv | 36 +++
 rtl/fp16_round_pipe.sv | 173 +++++++++++++++++
 tb/tb_fp16_round_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fp16Pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16Pkg
// Description : Shared FP16 types, widths and rounding-mode encodings for the
//               half-precision datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16Pkg;

    // Exponent / fraction most-significant bit indices
    localparam int EMSB = 4;
    localparam int FMSB = 9;

    // Largest finite magnitude, {exp, frac} without the sign
    localparam logic [EMSB+FMSB+1:0] FP16_MAXFIN = 15'h7BFF;

    // Packed IEEE 754 binary16
    typedef struct packed {
        logic            sign;
        logic [EMSB:0]   exp;
        logic [FMSB:0]   frac;
    } FP16;

    // Normalizer output: sig = {whole, fraction[9:0], G, R, S}
    typedef struct packed {
        logic            sign;
        logic [EMSB:0]   exp;
        logic [FMSB+4:0] sig;
    } FP16N;

    // Rounding modes; codes 5-7 fall back to round-to-nearest-even
    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rounding_mode_t;

endpackage
`default_nettype wire

// File: rtl/fp16_round_inc.sv
`default_nettype none
// ============================================================================
// Module      : fp16_round_inc
// Description : Combinational round-increment decision from sign, L/G/R/S and
//               the rounding mode. Precision-independent.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_round_inc
    import fp16Pkg::*;
(
    input  logic       i_sign,
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_round,
    input  logic       i_sticky,
    input  logic [2:0] i_rm,
    output logic       o_inc
);

    logic w_any_discard;

    // Select the increment rule for the requested mode
    always_comb begin
        w_any_discard = i_guard | i_round | i_sticky;
        o_inc         = i_guard & (i_lsb | i_round | i_sticky);
        case (i_rm)
            RTZ:     o_inc = 1'b0;
            RDN:     o_inc = i_sign & w_any_discard;
            RUP:     o_inc = ~i_sign & w_any_discard;
            RMM:     o_inc = i_guard;
            default: o_inc = i_guard & (i_lsb | i_round | i_sticky);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fp16_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp16_round_pipe
// Description : Two-stage FP16 rounding pipeline. Stage 1 decides the round
//               increment, stage 2 applies it, handles overflow and packs the
//               result with exception flags. Valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_round_pipe
    import fp16Pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  FP16N       i,
    input  logic       under_i,
    input  logic       inexact_i,
    input  logic [2:0] rm,
    output logic       out_valid,
    input  logic       out_ready,
    output FP16        o,
    output logic       inexact_o,
    output logic       overflow_o,
    output logic       underflow_o
);

    localparam logic [EMSB:0] C_EXP_SPECIAL = '1;
    localparam logic [14:0]   C_INF_MAG     = 15'h7C00;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_adv1;
    logic w_adv2;
    logic r_s1_valid;

    assign w_adv2   = ~out_valid | out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign in_ready = w_adv1;

    // ------------------------------------------------------------------
    // Stage 1: decision
    // ------------------------------------------------------------------
    logic          w_inc;
    logic          w_special;
    logic [FMSB:0] w_frac_in;
    logic [FMSB:0] w_frac_s1;
    logic          w_unused_whole;

    // The whole bit carries no information here: exp==0 already marks denormals
    assign w_unused_whole = i.sig[FMSB+4];

    fp16_round_inc u_round_inc (
        .i_sign   (i.sign),
        .i_lsb    (i.sig[3]),
        .i_guard  (i.sig[2]),
        .i_round  (i.sig[1]),
        .i_sticky (i.sig[0]),
        .i_rm     (rm),
        .o_inc    (w_inc)
    );

    // Specials pass the fraction through; a NaN payload is forced quiet
    always_comb begin
        w_special = (i.exp == C_EXP_SPECIAL);
        w_frac_in = i.sig[FMSB+3:3];
        w_frac_s1 = w_frac_in;
        if (w_special && (w_frac_in != '0)) begin
            w_frac_s1 = {1'b1, w_frac_in[FMSB-1:0]};
        end
    end

    logic          r_s1_sign;
    logic [EMSB:0] r_s1_exp;
    logic [FMSB:0] r_s1_frac;
    logic          r_s1_guard;
    logic          r_s1_round;
    logic          r_s1_sticky;
    logic [2:0]    r_s1_rm;
    logic          r_s1_under;
    logic          r_s1_inexact;
    logic          r_s1_inc;
    logic          r_s1_special;

    // Stage 1 register bank, loads whenever stage 1 may advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_frac    <= '0;
            r_s1_guard   <= 1'b0;
            r_s1_round   <= 1'b0;
            r_s1_sticky  <= 1'b0;
            r_s1_rm      <= '0;
            r_s1_under   <= 1'b0;
            r_s1_inexact <= 1'b0;
            r_s1_inc     <= 1'b0;
            r_s1_special <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign    <= i.sign;
                r_s1_exp     <= i.exp;
                r_s1_frac    <= w_frac_s1;
                r_s1_guard   <= i.sig[2];
                r_s1_round   <= i.sig[1];
                r_s1_sticky  <= i.sig[0];
                r_s1_rm      <= rm;
                r_s1_under   <= under_i;
                r_s1_inexact <= inexact_i;
                r_s1_inc     <= w_inc & ~w_special;
                r_s1_special <= w_special;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: apply
    // ------------------------------------------------------------------
    logic [14:0] w_sum;
    logic [14:0] w_mag;
    logic        w_at_maxfin;
    logic        w_overflow;
    logic        w_to_inf;
    logic        w_inexact;
    logic        w_underflow;

    // Add the increment, detect overflow and choose inf vs max-finite.
    // A value sitting at max finite with at least a half-ulp discarded counts
    // as overflow even in modes that truncate it back to max finite.
    always_comb begin
        w_sum       = {r_s1_exp, r_s1_frac} + {14'd0, r_s1_inc};
        w_at_maxfin = ({r_s1_exp, r_s1_frac} == FP16_MAXFIN);
        w_overflow  = ~r_s1_special &
                      ((&w_sum[14:10]) | (w_at_maxfin & r_s1_guard));
        case (r_s1_rm)
            RTZ:     w_to_inf = 1'b0;
            RDN:     w_to_inf = r_s1_sign;
            RUP:     w_to_inf = ~r_s1_sign;
            default: w_to_inf = 1'b1;
        endcase
        w_mag = w_sum;
        if (w_overflow) begin
            w_mag = w_to_inf ? C_INF_MAG : FP16_MAXFIN;
        end
        w_inexact   = ~r_s1_special &
                      (r_s1_guard | r_s1_round | r_s1_sticky | r_s1_inexact | w_overflow);
        w_underflow = r_s1_under & w_inexact;
    end

    // Output register bank; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            o           <= '0;
            inexact_o   <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (w_adv2) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o           <= {r_s1_sign, w_mag};
                inexact_o   <= w_inexact;
                overflow_o  <= w_overflow;
                underflow_o <= w_underflow;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_round_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_round_pipe
// Description : Directed self-checking bench for fp16_round_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_round_pipe;
    import fp16Pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    FP16N       i;
    logic       under_i;
    logic       inexact_i;
    logic [2:0] rm;
    logic       out_valid;
    logic       out_ready;
    FP16        o;
    logic       inexact_o;
    logic       overflow_o;
    logic       underflow_o;

    int n_vec = 0;
    int n_bad = 0;

    fp16_round_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .i           (i),
        .under_i     (under_i),
        .inexact_i   (inexact_i),
        .rm          (rm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .o           (o),
        .inexact_o   (inexact_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One beat through an empty pipe; flags are {inexact, overflow, underflow}
    task automatic run_vec(input string tag, input logic s, input logic [4:0] e,
                           input logic [13:0] sg, input logic un, input logic ix,
                           input logic [2:0] m, input logic [15:0] eo, input logic [2:0] ef);
        int waited = 0;
        @(negedge clk);
        i         = '{sign: s, exp: e, sig: sg};
        under_i   = un;
        inexact_i = ix;
        rm        = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        i         = '1;
        under_i   = ~un;
        inexact_i = ~ix;
        rm        = 3'd7;
        while (!out_valid && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({tag, "_latency"}, waited, 1);
        check({tag, "_o"}, o, eo);
        check({tag, "_flags"}, {inexact_o, overflow_o, underflow_o}, ef);
    endtask

    initial begin
        logic        m_s1;
        logic        m_s2;
        logic        adv1;
        logic        adv2;
        logic        was_stall;
        logic        saw_block;
        logic [15:0] held;
        int          sent;
        int          recvd;

        // Reset state
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        i         = '0;
        under_i   = 1'b0;
        inexact_i = 1'b0;
        rm        = 3'd0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_o", o, 16'h0000);
        check("rst_flags", {inexact_o, overflow_o, underflow_o}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_idle", out_valid, 0);

        // Directed rounding vectors
        run_vec("rne_tie_odd",    1'b0, 5'd15, 14'h200C, 1'b0, 1'b0, 3'd0, 16'h3C02, 3'b100);
        run_vec("rne_tie_even",   1'b0, 5'd15, 14'h2004, 1'b0, 1'b0, 3'd0, 16'h3C00, 3'b100);
        run_vec("rup_carry",      1'b0, 5'd15, 14'h3FFC, 1'b0, 1'b0, 3'd3, 16'h4000, 3'b100);
        run_vec("ovf_rne",        1'b0, 5'd30, 14'h3FFC, 1'b0, 1'b0, 3'd0, 16'h7C00, 3'b110);
        run_vec("ovf_rtz",        1'b0, 5'd30, 14'h3FFC, 1'b0, 1'b0, 3'd1, 16'h7BFF, 3'b110);
        run_vec("ovf_rup_neg",    1'b1, 5'd30, 14'h3FFC, 1'b0, 1'b0, 3'd3, 16'hFBFF, 3'b110);
        run_vec("ovf_rmm_neg",    1'b1, 5'd30, 14'h3FFC, 1'b0, 1'b0, 3'd4, 16'hFC00, 3'b110);
        run_vec("denorm_to_norm", 1'b0, 5'd0,  14'h1FFC, 1'b1, 1'b0, 3'd0, 16'h0400, 3'b101);
        run_vec("zero",           1'b0, 5'd0,  14'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b000);
        run_vec("inf",            1'b0, 5'd31, 14'h2007, 1'b0, 1'b0, 3'd0, 16'h7C00, 3'b000);
        run_vec("nan_quiet",      1'b0, 5'd31, 14'h200F, 1'b0, 1'b0, 3'd3, 16'h7E01, 3'b000);
        run_vec("rdn_neg_r",      1'b1, 5'd15, 14'h2002, 1'b0, 1'b0, 3'd2, 16'hBC01, 3'b100);
        run_vec("rup_pos_s",      1'b0, 5'd15, 14'h2001, 1'b0, 1'b0, 3'd3, 16'h3C01, 3'b100);
        run_vec("rmm_half",       1'b0, 5'd15, 14'h2004, 1'b0, 1'b0, 3'd4, 16'h3C01, 3'b100);
        run_vec("rm6_as_rne",     1'b0, 5'd15, 14'h2004, 1'b0, 1'b0, 3'd6, 16'h3C00, 3'b100);
        run_vec("upstream_inx",   1'b0, 5'd15, 14'h2000, 1'b0, 1'b1, 3'd0, 16'h3C00, 3'b100);
        run_vec("exact_tiny",     1'b0, 5'd0,  14'h0800, 1'b1, 1'b0, 3'd0, 16'h0100, 3'b000);

        // Drain, then stream 5 beats with out_ready low in cycles 3..6
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        m_s1      = 1'b0;
        m_s2      = 1'b0;
        was_stall = 1'b0;
        saw_block = 1'b0;
        held      = '0;
        sent      = 0;
        recvd     = 0;
        for (int cyc = 0; cyc < 40 && recvd < 5; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 5);
            i         = '{sign: 1'b0, exp: 5'd15, sig: {1'b1, 10'(sent + 1), 3'b000}};
            rm        = 3'd0;
            under_i   = 1'b0;
            inexact_i = 1'b0;
            #1;
            check("bp_in_ready", in_ready, !m_s1 || !m_s2 || out_ready);
            check("bp_out_valid", out_valid, m_s2);
            if (was_stall) check("bp_hold", o, held);
            was_stall = out_valid & !out_ready;
            held      = o;
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                check("bp_order", o, 16'h3C00 + 16'(recvd + 1));
                recvd++;
            end
            adv2 = !m_s2 || out_ready;
            adv1 = !m_s1 || adv2;
            if (adv2) m_s2 = m_s1;
            if (adv1) m_s1 = in_valid;
            if (in_valid && in_ready) sent++;
        end
        check("bp_all_received", recvd, 5);
        check("bp_input_blocked", saw_block, 1);

        // Reset mid-stream discards in-flight beats
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        i         = '{sign: 1'b0, exp: 5'd15, sig: 14'h2008};
        @(negedge clk);
        i         = '{sign: 1'b0, exp: 5'd15, sig: 14'h2010};
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
        check("midrst_pre_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_o", o, 16'h0000);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_discard", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("midrst_still_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
